// File: rtl/vga_frame_monitor_if.sv
// VGA display bus: active-low syncs plus 4-bit-per-channel colour, sampled on the pixel clock.
// The source drives through master; passive monitors observe through slave.
interface vga_frame_monitor_if;
    logic       hsync;
    logic       vsync;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;

    modport master (output hsync, vsync, vga_r, vga_g, vga_b);
    modport slave  (input  hsync, vsync, vga_r, vga_g, vga_b);
endinterface

// File: rtl/vga_frame_monitor.sv
// Passive VGA sink checker: rebuilds raster position, validates sync timing, locks on clean frames.
// Statistics publish one cycle after the closing vsync fall; no backpressure, every clock is sampled.
module vga_frame_monitor #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic               clk25,
    input  logic               reset,
    vga_frame_monitor_if.slave vga,
    input  logic [9:0]         probe_x,
    input  logic [9:0]         probe_y,
    output logic               locked,
    output logic               frame_done,
    output logic [15:0]        frame_count,
    output logic [7:0]         err_count,
    output logic [18:0]        lit_count,
    output logic [11:0]        probe_rgb
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_FRAME  = 10'(V_TOTAL);
    localparam logic [9:0] HS_WIDTH = 10'(H_SYNC);
    localparam logic [9:0] H_OFS    = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] V_OFS    = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] POS_MAX  = 10'h3FF;

    typedef enum logic [1:0] {ST_UNLOCKED, ST_MEASURE, ST_LOCKED} state_e;

    state_e      state_q, state_d;
    logic        hs_prev_q, hs_prev_d;
    logic        vs_prev_q, vs_prev_d;
    logic        hs_seen_q, hs_seen_d;
    logic [9:0]  h_pos_q, h_pos_d;
    logic [9:0]  v_pos_q, v_pos_d;
    logic [9:0]  hs_low_q, hs_low_d;
    logic        frame_bad_q, frame_bad_d;
    logic [18:0] lit_acc_q, lit_acc_d;
    logic [11:0] probe_acc_q, probe_acc_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [18:0] lit_count_q, lit_count_d;
    logic [11:0] probe_rgb_q, probe_rgb_d;

    logic [11:0] rgb;
    logic        hs_fall, hs_rise, vs_fall, tracking, visible, pix_err, watchdog;
    logic [9:0]  col, row;
    logic [7:0]  err_inc;

    always_comb begin
        rgb       = {vga.vga_r, vga.vga_g, vga.vga_b};
        hs_fall   = hs_prev_q & ~vga.hsync;
        hs_rise   = ~hs_prev_q & vga.hsync;
        vs_fall   = vs_prev_q & ~vga.vsync;
        tracking  = (state_q != ST_UNLOCKED);
        hs_prev_d = vga.hsync;
        vs_prev_d = vga.vsync;
        err_inc   = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;

        // h_pos_d/v_pos_d are this cycle's raster position; the _q copies are last cycle's.
        if (hs_fall)                 h_pos_d = '0;
        else if (h_pos_q == POS_MAX) h_pos_d = POS_MAX;
        else                         h_pos_d = h_pos_q + 10'd1;

        if (vs_fall)                           v_pos_d = '0;
        else if (hs_fall && v_pos_q != POS_MAX) v_pos_d = v_pos_q + 10'd1;
        else                                   v_pos_d = v_pos_q;

        hs_low_d = hs_low_q;
        if (!vga.hsync) begin
            if (hs_fall)                   hs_low_d = 10'd1;
            else if (hs_low_q != POS_MAX)  hs_low_d = hs_low_q + 10'd1;
        end

        col     = h_pos_d - H_OFS;
        row     = v_pos_d - V_OFS;
        visible = (col < H_VIS) && (row < V_VIS);

        pix_err = tracking && ((hs_fall && hs_seen_q && (h_pos_q != H_LAST))
                            || (hs_rise && (hs_low_q != HS_WIDTH))
                            || (!visible && (rgb != 12'h000)));
        watchdog  = tracking && ((h_pos_d == POS_MAX) || (v_pos_d == POS_MAX));
        hs_seen_d = (hs_seen_q | hs_fall) & ~watchdog;

        lit_acc_d   = lit_acc_q;
        probe_acc_d = probe_acc_q;
        frame_bad_d = frame_bad_q | pix_err;
        if (visible && (rgb != 12'h000)) lit_acc_d = lit_acc_q + 19'd1;
        if (visible && (col == probe_x) && (row == probe_y)) probe_acc_d = rgb;
        if (vs_fall) begin
            lit_acc_d   = '0;
            probe_acc_d = '0;
            frame_bad_d = 1'b0;
        end

        state_d       = state_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        lit_count_d   = lit_count_q;
        probe_rgb_d   = probe_rgb_q;
        if (watchdog) begin
            state_d     = ST_UNLOCKED;
            err_count_d = err_inc;
        end else if (vs_fall) begin
            if (state_q == ST_UNLOCKED) begin
                state_d = ST_MEASURE;
            end else if (!frame_bad_q && (v_pos_q == V_FRAME)) begin
                state_d       = ST_LOCKED;
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
                lit_count_d   = lit_acc_q;
                probe_rgb_d   = probe_acc_q;
            end else begin
                state_d     = ST_MEASURE;
                err_count_d = err_inc;
            end
        end
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            state_q       <= ST_UNLOCKED;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            hs_seen_q     <= 1'b0;
            h_pos_q       <= '0;
            v_pos_q       <= '0;
            hs_low_q      <= '0;
            frame_bad_q   <= 1'b0;
            lit_acc_q     <= '0;
            probe_acc_q   <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            err_count_q   <= '0;
            lit_count_q   <= '0;
            probe_rgb_q   <= '0;
        end else begin
            state_q       <= state_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            hs_seen_q     <= hs_seen_d;
            h_pos_q       <= h_pos_d;
            v_pos_q       <= v_pos_d;
            hs_low_q      <= hs_low_d;
            frame_bad_q   <= frame_bad_d;
            lit_acc_q     <= lit_acc_d;
            probe_acc_q   <= probe_acc_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
            lit_count_q   <= lit_count_d;
            probe_rgb_q   <= probe_rgb_d;
        end
    end

    assign locked      = (state_q == ST_LOCKED);
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
    assign lit_count   = lit_count_q;
    assign probe_rgb   = probe_rgb_q;
endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor on a reduced 40x40 raster (58 x 47 totals) so full frames stay short.
// Expected frame-close results are queued with each frame; a monitor pops one per output change.
module tb_vga_frame_monitor;
    localparam int HV = 40, HF = 4, HS = 8, HB = 6;
    localparam int VV = 40, VF = 2, VS = 2, VB = 3;
    localparam int HT   = HV + HF + HS + HB;
    localparam int VT   = VV + VF + VS + VB;
    localparam int HOFS = HS + HB;
    localparam int VOFS = VS + VB;

    logic        clk25 = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  probe_x = '0;
    logic [9:0]  probe_y = '0;
    logic        locked, frame_done;
    logic [15:0] frame_count;
    logic [7:0]  err_count;
    logic [18:0] lit_count;
    logic [11:0] probe_rgb;

    vga_frame_monitor_if vga ();

    vga_frame_monitor #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_dut (
        .clk25(clk25), .reset(reset), .vga(vga),
        .probe_x(probe_x), .probe_y(probe_y),
        .locked(locked), .frame_done(frame_done), .frame_count(frame_count),
        .err_count(err_count), .lit_count(lit_count), .probe_rgb(probe_rgb)
    );

    always #20 clk25 = ~clk25;

    typedef struct packed {
        logic        lock;
        logic [15:0] fc;
        logic [7:0]  ec;
        logic [18:0] lit;
        logic [11:0] prb;
    } snap_t;

    typedef struct packed {
        logic  done;
        snap_t s;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ev_num = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic done, input logic lock, input int fc, input int ec,
                            input int lit, input logic [11:0] prb);
        obs_t o;
        o.done  = done;
        o.s.lock = lock;
        o.s.fc  = 16'(fc);
        o.s.ec  = 8'(ec);
        o.s.lit = 19'(lit);
        o.s.prb = prb;
        exp_q.push_back(o);
    endtask

    task automatic drive(input logic hs, input logic vs, input logic [11:0] pix, input logic rst);
        vga.hsync = hs;
        vga.vsync = vs;
        {vga.vga_r, vga.vga_g, vga.vga_b} = pix;
        reset = rst;
        @(posedge clk25);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 12'h000, 1'b0);
    endtask

    // One frame starting at the hsync fall of line 0; vsync falls at hc == HOFS of line 0.
    // Negative line numbers disable the corresponding fault injection.
    task automatic gen_frame(input bit sprite, input int stretch_vc, input int narrow_vc,
                             input int blank_vc, input int rst_vc);
        int          len, hs_w, col, row;
        logic        vs_low, vis;
        logic [11:0] pix;
        for (int vc = 0; vc < VT; vc++) begin
            len  = (vc == stretch_vc) ? HT + 1 : HT;
            hs_w = (vc == narrow_vc) ? HS - 1 : HS;
            for (int hc = 0; hc < len; hc++) begin
                col    = hc - HOFS;
                row    = vc - VOFS;
                vis    = (col >= 0) && (col < HV) && (row >= 0) && (row < VV);
                vs_low = ((vc == 0) && (hc >= HOFS)) || ((vc > 0) && (vc < VS))
                      || ((vc == VS) && (hc < HOFS));
                pix = 12'h000;
                if (sprite && vis && (col >= 20) && (col < 28) && (row >= 25) && (row < 33))
                    pix = 12'h0F0;
                if ((vc == blank_vc) && (hc == 2))
                    pix = 12'h001;
                drive(hc >= hs_w, !vs_low, pix, (vc == rst_vc) && (hc == 20));
            end
        end
    endtask

    initial begin : monitor
        snap_t prev, cur;
        obs_t  e;
        prev = '0;
        forever begin
            @(negedge clk25);
            cur = {locked, frame_count, err_count, lit_count, probe_rgb};
            if (mon_en && ((frame_done === 1'b1) || (cur !== prev))) begin
                ev_num++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ev%0d_unexpected: got done=%0b lock=%0b fc=%0d ec=%0d lit=%0d prb=0x%0h, expected no output change",
                             ev_num, frame_done, locked, frame_count, err_count, lit_count, probe_rgb);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("ev%0d_frame_done", ev_num), 32'(frame_done), 32'(e.done));
                    chk($sformatf("ev%0d_locked", ev_num), 32'(locked), 32'(e.s.lock));
                    chk($sformatf("ev%0d_frame_count", ev_num), 32'(frame_count), 32'(e.s.fc));
                    chk($sformatf("ev%0d_err_count", ev_num), 32'(err_count), 32'(e.s.ec));
                    chk($sformatf("ev%0d_lit_count", ev_num), 32'(lit_count), 32'(e.s.lit));
                    chk($sformatf("ev%0d_probe_rgb", ev_num), 32'(probe_rgb), 32'(e.s.prb));
                end
            end
            prev = cur;
        end
    end

    initial begin : stim
        vga.hsync = 1'b1;
        vga.vsync = 1'b1;
        {vga.vga_r, vga.vga_g, vga.vga_b} = 12'h000;
        reset = 1'b1;
        repeat (4) @(posedge clk25);
        #2;
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_frame_count", 32'(frame_count), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        chk("reset_lit_count", 32'(lit_count), 32'd0);
        chk("reset_probe_rgb", 32'(probe_rgb), 32'd0);
        mon_en = 1'b1;

        // Black frames: first vsync fall only starts measuring, then one good close per frame.
        gen_frame(1'b0, -1, -1, -1, -1);
        for (int k = 1; k <= 5; k++) begin
            push_exp(1'b1, 1'b1, k, 0, 0, 12'h000);
            gen_frame(1'b0, -1, -1, -1, -1);
        end

        // 8x8 green sprite at (20,25); probe inside it, then off-screen.
        probe_x = 10'd23;
        probe_y = 10'd28;
        push_exp(1'b1, 1'b1, 6, 0, 0, 12'h000);
        gen_frame(1'b1, -1, -1, -1, -1);
        probe_x = 10'd50;
        probe_y = 10'd10;
        push_exp(1'b1, 1'b1, 7, 0, 64, 12'h0F0);
        gen_frame(1'b1, -1, -1, -1, -1);

        // Line 10 one cycle long: lock lost, published stats held, then relock.
        push_exp(1'b1, 1'b1, 8, 0, 64, 12'h000);
        gen_frame(1'b0, 10, -1, -1, -1);
        push_exp(1'b0, 1'b0, 8, 1, 64, 12'h000);
        gen_frame(1'b0, -1, -1, -1, -1);

        // Narrow hsync pulse, recover, then colour during blanking, recover.
        push_exp(1'b1, 1'b1, 9, 1, 0, 12'h000);
        gen_frame(1'b0, -1, 30, -1, -1);
        push_exp(1'b0, 1'b0, 9, 2, 0, 12'h000);
        gen_frame(1'b0, -1, -1, -1, -1);
        push_exp(1'b1, 1'b1, 10, 2, 0, 12'h000);
        gen_frame(1'b0, -1, -1, 20, -1);
        push_exp(1'b0, 1'b0, 10, 3, 0, 12'h000);
        gen_frame(1'b0, -1, -1, -1, -1);

        // hsync stuck high long enough to saturate h_pos while locked.
        push_exp(1'b1, 1'b1, 11, 3, 0, 12'h000);
        gen_frame(1'b0, -1, -1, -1, -1);
        push_exp(1'b0, 1'b0, 11, 4, 0, 12'h000);
        idle(1100);
        gen_frame(1'b0, -1, -1, -1, -1);

        // Relock, then a one-cycle reset in the middle of a frame.
        push_exp(1'b1, 1'b1, 12, 4, 0, 12'h000);
        push_exp(1'b0, 1'b0, 0, 0, 0, 12'h000);
        gen_frame(1'b0, -1, -1, -1, 25);
        gen_frame(1'b0, -1, -1, -1, -1);
        push_exp(1'b1, 1'b1, 1, 0, 0, 12'h000);
        gen_frame(1'b0, -1, -1, -1, -1);
        idle(10);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
